// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard controller:
// scancode prefixes, the decoder state enum and the packed key-event record.
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_E0,
    ST_F0,
    ST_E0F0
  } ps2_dec_state_t;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } ps2_evt_t;

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: input synchronisers, falling-edge strobe,
// 11-bit frame capture and check. PS2_KBD_TIMEOUT_EN adds a stalled-frame abort.
module ps2_rx_frame #(
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  logic [2:0] r_clk_sync;
  logic [1:0] r_data_sync;
  logic [3:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic       r_start;
  logic       r_parity;
  logic       r_byte_valid;
  logic [7:0] r_byte_data;
  logic       r_frame_err;
  logic       w_strobe;
  logic       w_bit;
  logic       w_timeout;

  assign w_strobe = r_clk_sync[2] & ~r_clk_sync[1];
  assign w_bit    = r_data_sync[1];

`ifdef PS2_KBD_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYC + 1);
  logic [IW-1:0] r_idle;

  always_ff @(posedge clk) begin
    if (!resetn || w_strobe || r_bit_cnt == 4'd0) r_idle <= '0;
    else                                          r_idle <= r_idle + 1'b1;
  end

  // A real edge arriving on the expiry cycle keeps the frame alive.
  assign w_timeout = (r_bit_cnt != 4'd0) && (r_idle == IW'(TIMEOUT_CYC)) && !w_strobe;
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_clk_sync   <= 3'b111;
      r_data_sync  <= 2'b11;
      r_bit_cnt    <= 4'd0;
      r_shift      <= 8'd0;
      r_start      <= 1'b0;
      r_parity     <= 1'b0;
      r_byte_valid <= 1'b0;
      r_byte_data  <= 8'd0;
      r_frame_err  <= 1'b0;
    end else begin
      r_clk_sync   <= {r_clk_sync[1:0], ps2_clk};
      r_data_sync  <= {r_data_sync[0], ps2_data};
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      if (w_timeout) begin
        r_bit_cnt   <= 4'd0;
        r_frame_err <= 1'b1;
      end else if (w_strobe) begin
        if (r_bit_cnt == 4'd10) begin
          r_bit_cnt <= 4'd0;
          // Odd parity: data bits plus parity bit must XOR to 1.
          if (!r_start && w_bit && ((^r_shift) ^ r_parity)) begin
            r_byte_valid <= 1'b1;
            r_byte_data  <= r_shift;
          end else begin
            r_frame_err <= 1'b1;
          end
        end else begin
          r_bit_cnt <= r_bit_cnt + 4'd1;
          if (r_bit_cnt == 4'd0)      r_start  <= w_bit;
          else if (r_bit_cnt <= 4'd8) r_shift  <= {w_bit, r_shift[7:1]};
          else                        r_parity <= w_bit;
        end
      end
    end
  end

  assign byte_valid = r_byte_valid;
  assign byte_data  = r_byte_data;
  assign frame_err  = r_frame_err;

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard event controller: frame receiver, set-2 prefix decoder and FWFT
// event FIFO with valid/ready output. PS2_KBD_TIMEOUT_EN enables frame timeout.
module ps2_kbd_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_release,
  output logic       evt_ext,
  output logic       overflow,
  input  logic       clr_overflow,
  output logic       frame_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic           w_byte_valid;
  logic [7:0]     w_byte_data;
  logic           w_frame_err;
  ps2_dec_state_t r_state, w_state_next;
  logic           w_push;
  ps2_evt_t       w_push_evt;
  logic           w_pop;
  logic           w_push_ok;
  logic           w_nonempty;
  ps2_evt_t       w_head;
  ps2_evt_t       r_mem [FIFO_DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           r_overflow;

  ps2_rx_frame #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
    .clk        (clk),
    .resetn     (resetn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .byte_valid (w_byte_valid),
    .byte_data  (w_byte_data),
    .frame_err  (w_frame_err)
  );

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next    = r_state;
    w_push          = 1'b0;
    w_push_evt      = '0;
    w_push_evt.code = w_byte_data;
    if (w_frame_err) begin
      w_state_next = ST_IDLE;
    end else if (w_byte_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (w_byte_data == PS2_PREFIX_EXT)      w_state_next = ST_E0;
          else if (w_byte_data == PS2_PREFIX_BRK) w_state_next = ST_F0;
          else                                    w_push = 1'b1;
        end
        ST_E0: begin
          if (w_byte_data == PS2_PREFIX_BRK) begin
            w_state_next = ST_E0F0;
          end else if (w_byte_data != PS2_PREFIX_EXT) begin
            w_push         = 1'b1;
            w_push_evt.ext = 1'b1;
            w_state_next   = ST_IDLE;
          end
        end
        ST_F0: begin
          w_push         = 1'b1;
          w_push_evt.rel = 1'b1;
          w_state_next   = ST_IDLE;
        end
        default: begin
          w_push         = 1'b1;
          w_push_evt.ext = 1'b1;
          w_push_evt.rel = 1'b1;
          w_state_next   = ST_IDLE;
        end
      endcase
    end
  end

  assign w_nonempty = (r_count != '0);
  assign w_pop      = w_nonempty & evt_ready;
  assign w_push_ok  = w_push & ((r_count != CW'(FIFO_DEPTH)) | w_pop);
  assign w_head     = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= w_push_evt;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn)                  r_overflow <= 1'b0;
    else if (w_push && !w_push_ok) r_overflow <= 1'b1;
    else if (clr_overflow)         r_overflow <= 1'b0;
  end

  // Head fields are masked while empty so stale RAM never reaches the outputs.
  assign evt_valid   = w_nonempty;
  assign evt_code    = w_nonempty ? w_head.code : 8'd0;
  assign evt_release = w_nonempty & w_head.rel;
  assign evt_ext     = w_nonempty & w_head.ext;
  assign overflow    = r_overflow;
  assign frame_err   = w_frame_err;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed self-checking bench for ps2_kbd_ctrl; timeout scenario runs only
// when PS2_KBD_TIMEOUT_EN is defined.
module tb_ps2_kbd_ctrl;

  localparam int DEPTH = 8;
  localparam int TMO   = 200;
  localparam int HALF  = 10;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       evt_valid;
  logic       evt_ready = 1'b0;
  logic [7:0] evt_code;
  logic       evt_release;
  logic       evt_ext;
  logic       overflow;
  logic       clr_overflow = 1'b0;
  logic       frame_err;

  int n_checks = 0;
  int n_fail   = 0;

  ps2_kbd_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_code     (evt_code),
    .evt_release  (evt_release),
    .evt_ext      (evt_ext),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    cyc(HALF);
    ps2_clk = 1'b0;
    cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  // Drives start..parity, then the stop-bit falling edge; returns at cycle N+1.
  task automatic frame_to_stop(input logic [7:0] b, input logic bad_par);
    logic par;
    par = (~^b) ^ bad_par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    ps2_data = 1'b1;
    cyc(HALF);
    ps2_clk = 1'b0;
    cyc(3);
  endtask

  task automatic frame_end();
    cyc(HALF - 3);
    ps2_clk = 1'b1;
    cyc(HALF);
  endtask

  task automatic send_frame(input logic [7:0] b);
    frame_to_stop(b, 1'b0);
    frame_end();
  endtask

  task automatic pop();
    evt_ready = 1'b1;
    cyc(1);
    evt_ready = 1'b0;
  endtask

  task automatic check_evt(input string name, input logic [7:0] code, input logic rel, input logic ext);
    n_checks++;
    if (evt_valid !== 1'b1 || evt_code !== code || evt_release !== rel || evt_ext !== ext) begin
      n_fail++;
      $display("FAIL %s: got v=%b code=%h rel=%b ext=%b, want v=1 code=%h rel=%b ext=%b",
               name, evt_valid, evt_code, evt_release, evt_ext, code, rel, ext);
    end else
      $display("ok   %s: code=%h rel=%b ext=%b", name, evt_code, evt_release, evt_ext);
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end else
      $display("ok   %s: %b", name, got);
  endtask

  task automatic check_all_zero(input string name);
    n_checks++;
    if ({evt_valid, evt_code, evt_release, evt_ext, overflow, frame_err} !== 13'd0) begin
      n_fail++;
      $display("FAIL %s: got v=%b code=%h rel=%b ext=%b ovf=%b ferr=%b, want all 0",
               name, evt_valid, evt_code, evt_release, evt_ext, overflow, frame_err);
    end else
      $display("ok   %s: all outputs 0", name);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    cyc(3);
    check_all_zero("reset_outputs");
    resetn = 1'b1;
    cyc(2);
    check_all_zero("after_reset_release");
  endtask

  task automatic test_make();
    evt_ready = 1'b1;
    frame_to_stop(8'h1C, 1'b0);
    check_bit("make_valid_N+1", evt_valid, 1'b0);
    cyc(1);
    check_evt("make_N+2", 8'h1C, 1'b0, 1'b0);
    cyc(1);
    check_bit("make_popped", evt_valid, 1'b0);
    evt_ready = 1'b0;
    frame_end();
  endtask

  task automatic test_break();
    send_frame(8'hF0);
    check_bit("break_prefix_no_event", evt_valid, 1'b0);
    send_frame(8'h1C);
    check_evt("break_1C", 8'h1C, 1'b1, 1'b0);
    pop();
    check_bit("break_drained", evt_valid, 1'b0);
  endtask

  task automatic test_ext_break();
    send_frame(8'hE0);
    send_frame(8'hF0);
    check_bit("extbrk_prefix_no_event", evt_valid, 1'b0);
    send_frame(8'h75);
    check_evt("extbrk_75", 8'h75, 1'b1, 1'b1);
    pop();
    send_frame(8'hE0);
    send_frame(8'h74);
    check_evt("ext_make_74", 8'h74, 1'b0, 1'b1);
    pop();
  endtask

  task automatic test_parity();
    send_frame(8'hE0);
    frame_to_stop(8'h1C, 1'b1);
    check_bit("parity_ferr_pulse", frame_err, 1'b1);
    cyc(1);
    check_bit("parity_ferr_one_cycle", frame_err, 1'b0);
    frame_end();
    check_bit("parity_no_event", evt_valid, 1'b0);
    send_frame(8'h32);
    check_evt("after_parity_32", 8'h32, 1'b0, 1'b0);
    pop();
    send_frame(8'hAA);
    check_bit("prefix_AA_not_special", evt_valid, 1'b1);
    pop();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) send_frame(8'h15 + 8'(i));
    check_bit("ovf_clear_at_full", overflow, 1'b0);
    send_frame(8'h1D);
    check_bit("ovf_set", overflow, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check_evt($sformatf("drain_%0d", i), 8'h15 + 8'(i), 1'b0, 1'b0);
      pop();
    end
    check_bit("drain_empty", evt_valid, 1'b0);
    check_bit("ovf_sticky", overflow, 1'b1);
    clr_overflow = 1'b1;
    cyc(1);
    clr_overflow = 1'b0;
    check_bit("ovf_cleared", overflow, 1'b0);
  endtask

`ifdef PS2_KBD_TIMEOUT_EN
  task automatic test_timeout();
    bit seen;
    seen = 1'b0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    for (int i = 0; i < TMO + 50 && !seen; i++) begin
      cyc(1);
      if (frame_err === 1'b1) seen = 1'b1;
    end
    check_bit("timeout_ferr", seen, 1'b1);
    send_frame(8'h1C);
    check_evt("after_timeout_1C", 8'h1C, 1'b0, 1'b0);
    pop();
  endtask
`endif

  task automatic test_reset_midframe();
    send_frame(8'h21);
    check_bit("pre_reset_valid", evt_valid, 1'b1);
    send_frame(8'hE0);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    resetn = 1'b0;
    cyc(2);
    check_all_zero("midframe_reset");
    resetn = 1'b1;
    cyc(2);
    send_frame(8'h1C);
    check_evt("after_reset_1C", 8'h1C, 1'b0, 1'b0);
    pop();
    check_bit("after_reset_empty", evt_valid, 1'b0);
  endtask

  initial begin
    test_reset();
    test_make();
    test_break();
    test_ext_break();
    test_parity();
    test_overflow();
`ifdef PS2_KBD_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_ctrl.md
# ps2_kbd_ctrl

Keyboard event controller that sits between the PS/2 pins and the CPU-side device logic in npc. It deserialises PS/2 device-to-host frames and runs the scancode-set-2 prefix state machine (E0 extended, F0 break). Decoded key events go into a small FIFO and are delivered over a valid/ready handshake. Malformed frames, and optionally stalled frames, resynchronise the receiver without corrupting later events.

## Interface
- `FIFO_DEPTH`, default 8: event FIFO entries; power of two, ≥2.
- `TIMEOUT_CYC`, default 50000: clk cycles of PS/2 clock inactivity that abort a partial frame. Used only when the timeout feature is compiled in.
- `clk`, input, 1: system clock.
- `resetn`, input, 1: synchronous, active-low reset.
- `ps2_clk`, input, 1: raw PS/2 clock, asynchronous.
- `ps2_data`, input, 1: raw PS/2 data, asynchronous.
- `evt_valid`, output, 1: FIFO head holds an event.
- `evt_ready`, input, 1: consumer accepts the head this cycle.
- `evt_code`, output, 8: scancode byte with prefixes stripped.
- `evt_release`, output, 1: event is a break (key up).
- `evt_ext`, output, 1: event was E0-prefixed.
- `overflow`, output, 1: sticky flag; an event was dropped because the FIFO was full.
- `clr_overflow`, input, 1: clears `overflow`.
- `frame_err`, output, 1: one-cycle pulse when a frame is discarded.

## Operation
- **Input sync:** 3-flop shift register on `ps2_clk`. Sample strobe = `sync[2] & ~sync[1]` (falling edge). `ps2_data` is sampled on the strobe cycle.
- **Frame receive:** bit counter 0..10 captures start, 8 data bits (LSB first), parity and stop.
  - On the 11th strobe, the frame is good iff start==0, stop==1 and the XOR of data+parity == 1 (odd parity).
  - Good frame: `byte_valid` strobe with the data byte. Bad frame: `frame_err` pulse.
  - The counter returns to 0 on the 11th strobe either way.
- **Decoder FSM:** states IDLE, E0, F0, E0F0. Transitions on `byte_valid`:
  - IDLE: 0xE0→E0; 0xF0→F0; any other byte→push {ext=0, rel=0, code}, stay IDLE.
  - E0: 0xF0→E0F0; 0xE0→stay E0; other→push {ext=1, rel=0}, go IDLE.
  - F0: any byte→push {ext=0, rel=1}, go IDLE.
  - E0F0: any byte→push {ext=1, rel=1}, go IDLE.
  - `frame_err` forces IDLE from any state.
  - 0xE1 and other bytes get no special handling.
- **FIFO:** 10-bit entries {ext, rel, code}, first-word-fall-through. Outputs are driven from the head entry.
  - Pop on `evt_valid & evt_ready`.
  - Push is accepted if not full, or if a pop occurs in the same cycle.
  - A rejected push drops the event and sets `overflow`.
  - Pointers wrap modulo FIFO_DEPTH. A separate count (width $clog2(FIFO_DEPTH)+1) distinguishes full from empty.
- **Overflow flag:** `clr_overflow` and an overflow event in the same cycle leave `overflow`=1 (set wins).
- **Reset:**
  - Sync flops reset to 3'b111 (bus idle high), so reset never creates a false edge.
  - Bit counter 0, FSM IDLE, FIFO empty.
  - `evt_valid`=0, `evt_code`=0, `evt_release`=0, `evt_ext`=0, `overflow`=0, `frame_err`=0.
  - A reset mid-frame discards the partial frame and any pending prefix.

## Timing
- Let cycle N be the strobe cycle of the stop bit.
- N+1: `byte_valid` (or `frame_err`) high for one cycle.
- N+2: the event is written and `evt_valid` is high if the FIFO was empty. Latency is 2 cycles from the stop-bit strobe.
- Prefix bytes produce no output and add no extra latency to the final byte.
- An event is removed in the cycle after the handshake. `evt_valid` stays high when further entries remain.
- `evt_valid` must not depend combinationally on `evt_ready`.

## Configuration
- `PS2_KBD_TIMEOUT_EN` defined:
  - An idle counter clears on every strobe and increments while the bit counter is ≠0.
  - When it reaches TIMEOUT_CYC: bit counter←0, `frame_err` pulses once, FSM←IDLE.
  - The counter does not run while the bit counter is 0.
- Undefined: no counter logic. A partial frame waits indefinitely for further edges.

## Structure
- Shared package `ps2_pkg` holds:
  - constants `PS2_PREFIX_EXT`=8'hE0 and `PS2_PREFIX_BRK`=8'hF0;
  - the decoder state enum;
  - the packed event typedef {ext, rel, code[7:0]}.
- One sub-module, `ps2_rx_frame`, covers sync, strobe, bit counter, frame check and timeout. Its outputs are `byte_valid`, `byte_data` and `frame_err`.
- Decoder FSM and FIFO stay in the top level.

## Test plan
- Make code: frame 0x1C, `evt_ready`=1 → one event code=1C, rel=0, ext=0, `evt_valid` at N+2.
- Break code: frames F0,1C → single event code=1C, rel=1, ext=0; no event for F0.
- Extended break: frames E0,F0,75 → single event code=75, rel=1, ext=1.
- Parity error: frame 0x1C with parity flipped → `frame_err` pulse, no event. A following good frame 0x32 → event 32.
- Overflow: `evt_ready`=0 and 9 make codes 0x15..0x1D with depth 8 → 8 events held, `overflow`=1, 0x1D lost.
  - Then drain: events come out in order 15..1C.
  - `clr_overflow` pulse → `overflow`=0.
- Timeout and reset (with `PS2_KBD_TIMEOUT_EN`):
  - 5 bits then idle for TIMEOUT_CYC → `frame_err`; next frame 0x1C decodes correctly.
  - `resetn`=0 mid-frame → all outputs 0; the next full frame decodes correctly.
